mem_bridge: RTL and testbench

- Sits between the multicycle RV32I core (datapath + control FSM) and physical memory.
- Accepts one CPU read or write at a time, registers it, drives a request/response handshake on the pmem side, and returns a single-cycle cpu_resp with captured read data.
- Decouples core timing from variable memory latency; at most one outstanding transaction.

---
 rtl/mem_bridge.sv | 176 +++++++++++++++++
 tb/tb_mem_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge
// Description : Single-outstanding CPU-to-physical-memory bridge. It registers
//               one core read or write, runs the pmem request/response
//               handshake and returns a one-cycle cpu_resp. Optional watchdog
//               abort is enabled with the MEM_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_mbe,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    output logic        bus_err,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("mem_bridge: TIMEOUT_CYCLES out of range 1..65535");
    end

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_take_write;
    logic        w_take_read;
    logic        w_complete;
    logic        w_abort;
    logic        w_timeout;

    logic        r_pmem_read;
    logic        r_pmem_write;
    logic [31:0] r_pmem_address;
    logic [31:0] r_pmem_wdata;
    logic [3:0]  r_pmem_mbe;
    logic [31:0] r_cpu_rdata;
    logic        r_cpu_resp;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_count;
    logic        r_bus_err;

    assign w_timeout = (r_count == c_TIMEOUT);

    // Counter restarts on every BUSY entry and only advances while waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= 16'd0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_take_write || w_take_read) begin
                r_count <= 16'd0;
            end else if ((r_state == c_BUSY) && !pmem_resp && !w_timeout) begin
                r_count <= r_count + 16'd1;
            end
            if (w_abort) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_take_write = 1'b0;
        w_take_read  = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            c_IDLE: begin
                // A simultaneous read and write resolves to the write.
                if (cpu_write) begin
                    w_take_write = 1'b1;
                    w_next_state = c_BUSY;
                end else if (cpu_read) begin
                    w_take_read  = 1'b1;
                    w_next_state = c_BUSY;
                end
            end
            c_BUSY: begin
                if (pmem_resp) begin
                    w_complete   = 1'b1;
                    w_next_state = c_DONE;
                end else if (w_timeout) begin
                    w_abort      = 1'b1;
                    w_next_state = c_DONE;
                end
            end
            c_DONE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= 32'd0;
            r_pmem_wdata   <= 32'd0;
            r_pmem_mbe     <= 4'd0;
            r_cpu_rdata    <= 32'd0;
            r_cpu_resp     <= 1'b0;
        end else begin
            r_cpu_resp <= 1'b0;
            if (w_take_write) begin
                r_pmem_write   <= 1'b1;
                r_pmem_address <= {cpu_address[31:2], 2'b00};
                r_pmem_wdata   <= cpu_wdata;
                r_pmem_mbe     <= cpu_mbe;
            end else if (w_take_read) begin
                r_pmem_read    <= 1'b1;
                r_pmem_address <= {cpu_address[31:2], 2'b00};
                r_pmem_mbe     <= 4'hF;
            end
            if (w_complete) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_cpu_resp   <= 1'b1;
                if (r_pmem_read) begin
                    r_cpu_rdata <= pmem_rdata;
                end
            end
            if (w_abort) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_cpu_resp   <= 1'b1;
            end
        end
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign pmem_mbe     = r_pmem_mbe;
    assign cpu_rdata    = r_cpu_rdata;
    assign cpu_resp     = r_cpu_resp;

endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bridge
// Description : Self-checking bench for mem_bridge: directed and randomized
//               transactions against a transaction-level expectation model.
//               Timeout scenario is compiled when MEM_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bridge;

    localparam int c_TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_mbe;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;
    logic        bus_err;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    int          n_tests;
    int          n_fail;
    logic [31:0] m_rdata;
    logic        m_bus_err;

    mem_bridge #(.TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_mbe      (cpu_mbe),
        .cpu_rdata    (cpu_rdata),
        .cpu_resp     (cpu_resp),
        .bus_err      (bus_err),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_mbe     (pmem_mbe),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_resp"}, {31'd0, cpu_resp}, 32'd0);
        chk({tag, "_rd"}, {31'd0, pmem_read}, 32'd0);
        chk({tag, "_wr"}, {31'd0, pmem_write}, 32'd0);
        chk({tag, "_rdata"}, cpu_rdata, m_rdata);
        chk({tag, "_err"}, {31'd0, bus_err}, {31'd0, m_bus_err});
    endtask

    // One complete transaction; pmem_resp arrives lat cycles after the request edge.
    task automatic do_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] mbe,
                          input int lat, input logic [31:0] rdata, input bit hold);
        logic [31:0] exp_addr;
        logic [3:0]  exp_mbe;
        bit          exp_rd;
        exp_rd   = rd && !wr;
        exp_addr = addr & 32'hFFFF_FFFC;
        exp_mbe  = wr ? mbe : 4'hF;
        cpu_write   = wr;
        cpu_read    = rd;
        cpu_address = addr;
        cpu_wdata   = wd;
        cpu_mbe     = mbe;
        for (int k = 1; k <= lat; k++) begin
            tick();
            chk("busy_rd", {31'd0, pmem_read}, {31'd0, exp_rd});
            chk("busy_wr", {31'd0, pmem_write}, {31'd0, wr});
            chk("busy_addr", pmem_address, exp_addr);
            chk("busy_mbe", {28'd0, pmem_mbe}, {28'd0, exp_mbe});
            if (wr) chk("busy_wdata", pmem_wdata, wd);
            chk("busy_resp", {31'd0, cpu_resp}, 32'd0);
            cpu_address = $urandom;
            cpu_wdata   = $urandom;
            cpu_mbe     = 4'($urandom);
            if (k == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rdata;
            end else begin
                pmem_rdata = $urandom;
            end
        end
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = $urandom;
        if (exp_rd) m_rdata = rdata;
        chk("done_resp", {31'd0, cpu_resp}, 32'd1);
        chk("done_rd", {31'd0, pmem_read}, 32'd0);
        chk("done_wr", {31'd0, pmem_write}, 32'd0);
        chk("done_rdata", cpu_rdata, m_rdata);
        chk("done_err", {31'd0, bus_err}, {31'd0, m_bus_err});
        if (!hold) begin
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
        end
        tick();
        chk_idle("post");
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] r;
        logic [3:0]  m;
        int          kind;
        int          lat;
        bit          hold;
        n_tests     = 0;
        n_fail      = 0;
        m_rdata     = 32'd0;
        m_bus_err   = 1'b0;
        rst         = 1'b0;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = 32'd0;
        cpu_wdata   = 32'd0;
        cpu_mbe     = 4'd0;
        pmem_rdata  = 32'd0;
        pmem_resp   = 1'b0;

        tick();
        tick();
        chk_idle("reset");
        chk("reset_addr", pmem_address, 32'd0);
        chk("reset_wdata", pmem_wdata, 32'd0);
        chk("reset_mbe", {28'd0, pmem_mbe}, 32'd0);
        rst = 1'b1;
        tick();
        chk_idle("idle0");

        // Directed read: resp at cycle 3, cpu_resp at cycle 4.
        do_txn(1'b0, 1'b1, 32'h0000_0063, 32'd0, 4'h0, 3, 32'h1234_5678, 1'b0);
        // Directed write with inputs perturbed during BUSY.
        do_txn(1'b1, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 4'b0011, 2, 32'hDEAD_BEEF, 1'b0);
        // Read and write together: write wins.
        do_txn(1'b1, 1'b1, 32'h0000_0208, 32'h0BAD_CAFE, 4'b1100, 1, 32'h5555_AAAA, 1'b0);

        // Spurious pmem_resp while idle.
        pmem_resp  = 1'b1;
        pmem_rdata = 32'hFFFF_0000;
        tick();
        pmem_resp = 1'b0;
        chk_idle("spur");
        tick();
        chk_idle("spur2");

        // Request held through DONE is re-issued as a second transaction.
        do_txn(1'b0, 1'b1, 32'h0000_0300, 32'd0, 4'h0, 1, 32'hA5A5_0001, 1'b1);
        do_txn(1'b0, 1'b1, 32'h0000_0300, 32'd0, 4'h0, 2, 32'hA5A5_0002, 1'b0);

        // Randomized transactions.
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom;
            d    = $urandom;
            r    = $urandom;
            m    = 4'($urandom);
            lat  = $urandom_range(1, 5);
            hold = ($urandom_range(0, 3) == 0);
            do_txn(kind != 1, kind != 0, a, d, m, lat, r, hold);
            if (hold) do_txn(kind != 1, kind != 0, a, d, m, lat + 1, ~r, 1'b0);
        end

        // Reset two cycles into BUSY.
        cpu_read    = 1'b1;
        cpu_address = 32'h0000_0404;
        tick();
        tick();
        chk("pre_rst_rd", {31'd0, pmem_read}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        m_rdata   = 32'd0;
        m_bus_err = 1'b0;
        chk_idle("async_rst");
        chk("rst_addr", pmem_address, 32'd0);
        chk("rst_mbe", {28'd0, pmem_mbe}, 32'd0);
        chk("rst_wdata", pmem_wdata, 32'd0);
        cpu_read = 1'b0;
        tick();
        chk_idle("in_rst");
        rst = 1'b1;
        tick();
        chk_idle("after_rst");
        do_txn(1'b0, 1'b1, 32'h0000_0410, 32'd0, 4'h0, 2, 32'h7777_1111, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No pmem_resp: strobe held TIMEOUT+1 cycles, cpu_resp on the next.
        cpu_read    = 1'b1;
        cpu_address = 32'h0000_0500;
        for (int k = 1; k <= c_TIMEOUT + 1; k++) begin
            tick();
            chk("to_busy_rd", {31'd0, pmem_read}, 32'd1);
            chk("to_busy_resp", {31'd0, cpu_resp}, 32'd0);
            chk("to_busy_err", {31'd0, bus_err}, 32'd0);
        end
        tick();
        m_bus_err = 1'b1;
        chk("to_resp", {31'd0, cpu_resp}, 32'd1);
        chk("to_rd", {31'd0, pmem_read}, 32'd0);
        chk("to_err", {31'd0, bus_err}, 32'd1);
        chk("to_rdata", cpu_rdata, m_rdata);
        cpu_read = 1'b0;
        tick();
        chk_idle("to_post");
        do_txn(1'b0, 1'b1, 32'h0000_0504, 32'd0, 4'h0, 3, 32'h2468_ACE0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
